// File: rtl/ext_sram_ctrl.sv
// SRAM-bus slave driving an external asynchronous 16-bit SRAM.
// Each 32-bit access becomes a low and a high halfword pin phase with programmable length.
module ext_sram_ctrl #(
  parameter int unsigned AW        = 32,
  parameter int unsigned SRAM_AW   = 18,
  parameter int unsigned RD_CYCLES = 2,
  parameter int unsigned WR_CYCLES = 3
) (
  input  logic               clk,
  input  logic               rst_b,
  input  logic               sram_req,
  input  logic               sram_write,
  input  logic [3:0]         sram_wstrb,
  input  logic [AW-1:0]      sram_addr,
  input  logic [31:0]        sram_wdata,
  output logic               sram_ready,
  output logic               sram_rvalid,
  output logic [31:0]        sram_rdata,
  output logic [SRAM_AW-1:0] ext_addr,
  output logic [15:0]        ext_dq_out,
  output logic               ext_dq_oe,
  input  logic [15:0]        ext_dq_in,
  output logic               ext_ce_n,
  output logic               ext_oe_n,
  output logic               ext_we_n,
  output logic               ext_ub_n,
  output logic               ext_lb_n
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] LO   = 3'd1;
  localparam logic [2:0] HI   = 3'd2;
  localparam logic [2:0] RESP = 3'd3;
  localparam logic [2:0] BUSY = 3'd4;

  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] RD_LAST = CW'(RD_CYCLES - 1);
  localparam logic [CW-1:0] WR_LAST = CW'(WR_CYCLES - 1);

  logic [2:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               write_q, write_d;
  logic [3:0]         wstrb_q, wstrb_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [SRAM_AW-2:0] idx_q, idx_d;
  logic [15:0]        lo_buf_q;
  logic               phase_end;

  logic [SRAM_AW-1:0] addr_d;
  logic [15:0]        dq_out_d;
  logic               dq_oe_d, ce_n_d, oe_n_d, we_n_d, ub_n_d, lb_n_d, hi_sel;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{sram_addr[AW-1:SRAM_AW+1], sram_addr[1:0]};

  assign sram_ready = (state_q == IDLE);
  assign phase_end  = (cnt_q == (write_q ? WR_LAST : RD_LAST));

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    write_d = write_q;
    wstrb_d = wstrb_q;
    wdata_d = wdata_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (sram_req) begin
          write_d = sram_write;
          wstrb_d = sram_wstrb;
          wdata_d = sram_wdata;
          idx_d   = sram_addr[SRAM_AW:2];
          // Writes skip any halfword whose two strobes are clear.
          if (!sram_write || (|sram_wstrb[1:0])) state_d = LO;
          else if (|sram_wstrb[3:2])             state_d = HI;
          else                                   state_d = BUSY;
        end
      end
      LO: begin
        if (phase_end) state_d = (write_q && (wstrb_q[3:2] == 2'b00)) ? IDLE : HI;
        else           cnt_d   = cnt_q + CW'(1);
      end
      HI: begin
        if (phase_end) state_d = write_q ? IDLE : RESP;
        else           cnt_d   = cnt_q + CW'(1);
      end
      RESP:    state_d = IDLE;
      BUSY:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pin values are derived from the next state so that every ext_* output is a flop.
  always_comb begin
    addr_d   = ext_addr;
    dq_out_d = ext_dq_out;
    dq_oe_d  = 1'b0;
    ce_n_d   = 1'b1;
    oe_n_d   = 1'b1;
    we_n_d   = 1'b1;
    ub_n_d   = 1'b1;
    lb_n_d   = 1'b1;
    hi_sel   = (state_d == HI);
    if ((state_d == LO) || (state_d == HI)) begin
      addr_d = {idx_d, hi_sel};
      ce_n_d = 1'b0;
      if (write_d) begin
        dq_oe_d          = 1'b1;
        dq_out_d         = hi_sel ? wdata_d[31:16] : wdata_d[15:0];
        {ub_n_d, lb_n_d} = ~(hi_sel ? wstrb_d[3:2] : wstrb_d[1:0]);
        we_n_d           = (cnt_d == WR_LAST);
      end else begin
        oe_n_d = 1'b0;
        ub_n_d = 1'b0;
        lb_n_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      write_q     <= 1'b0;
      wstrb_q     <= '0;
      wdata_q     <= '0;
      idx_q       <= '0;
      lo_buf_q    <= '0;
      sram_rvalid <= 1'b0;
      sram_rdata  <= '0;
      ext_addr    <= '0;
      ext_dq_out  <= '0;
      ext_dq_oe   <= 1'b0;
      ext_ce_n    <= 1'b1;
      ext_oe_n    <= 1'b1;
      ext_we_n    <= 1'b1;
      ext_ub_n    <= 1'b1;
      ext_lb_n    <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      write_q     <= write_d;
      wstrb_q     <= wstrb_d;
      wdata_q     <= wdata_d;
      idx_q       <= idx_d;
      sram_rvalid <= (state_d == RESP);
      ext_addr    <= addr_d;
      ext_dq_out  <= dq_out_d;
      ext_dq_oe   <= dq_oe_d;
      ext_ce_n    <= ce_n_d;
      ext_oe_n    <= oe_n_d;
      ext_we_n    <= we_n_d;
      ext_ub_n    <= ub_n_d;
      ext_lb_n    <= lb_n_d;
      // Low half is buffered so sram_rdata only changes when a whole word is ready.
      if ((state_q == LO) && !write_q && phase_end) lo_buf_q <= ext_dq_in;
      if ((state_q == HI) && !write_q && phase_end) sram_rdata <= {ext_dq_in, lo_buf_q};
    end
  end

endmodule

// File: tb/tb_ext_sram_ctrl.sv
// Self-checking bench for ext_sram_ctrl: directed pin-sequence tests plus a random
// scoreboard run against a behavioural 16-bit SRAM model.
module tb_ext_sram_ctrl;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        sram_req = 1'b0, sram_write = 1'b0;
  logic [3:0]  sram_wstrb = '0;
  logic [31:0] sram_addr = '0, sram_wdata = '0;
  logic        sram_ready, sram_rvalid;
  logic [31:0] sram_rdata;
  logic [17:0] ext_addr;
  logic [15:0] ext_dq_out, ext_dq_in;
  logic        ext_dq_oe, ext_ce_n, ext_oe_n, ext_we_n, ext_ub_n, ext_lb_n;

  always #5 clk = ~clk;

  ext_sram_ctrl dut (
    .clk        (clk),
    .rst_b      (rst_b),
    .sram_req   (sram_req),
    .sram_write (sram_write),
    .sram_wstrb (sram_wstrb),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_ready (sram_ready),
    .sram_rvalid(sram_rvalid),
    .sram_rdata (sram_rdata),
    .ext_addr   (ext_addr),
    .ext_dq_out (ext_dq_out),
    .ext_dq_oe  (ext_dq_oe),
    .ext_dq_in  (ext_dq_in),
    .ext_ce_n   (ext_ce_n),
    .ext_oe_n   (ext_oe_n),
    .ext_we_n   (ext_we_n),
    .ext_ub_n   (ext_ub_n),
    .ext_lb_n   (ext_lb_n)
  );

  // Behavioural SRAM
  logic [15:0] mem [0:(1<<18)-1];
  assign ext_dq_in = (!ext_ce_n && !ext_oe_n) ? mem[ext_addr] : 16'h0000;
  always @(posedge clk) begin
    if (!ext_ce_n && !ext_we_n) begin
      if (!ext_lb_n) mem[ext_addr][7:0]  <= ext_dq_out[7:0];
      if (!ext_ub_n) mem[ext_addr][15:8] <= ext_dq_out[15:8];
    end
  end

  typedef struct packed {
    logic [17:0] a;
    logic [15:0] d;
    logic        ub, lb, we, oe, dq_oe;
  } pin_t;

  pin_t        plog[$];
  logic [31:0] exp_q[$];
  logic [31:0] ref_mem [0:(1<<17)-1];
  int          n_tests = 0, n_fail = 0;
  int          cyc = 0, acc_cyc = 0, rv_cyc = 0, rv_cnt = 0, busy_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_b) begin
      if (!ext_ce_n) plog.push_back({ext_addr, ext_dq_out, ext_ub_n, ext_lb_n, ext_we_n,
                                     ext_oe_n, ext_dq_oe});
      if (!sram_ready) busy_cnt++;
      if (sram_rvalid) begin
        rv_cnt++;
        rv_cyc = cyc;
        if (exp_q.size() == 0) check("rv_unexpected", 32'd1, 32'd0);
        else                   check("rdata", sram_rdata, exp_q.pop_front());
      end
    end
  end

  task automatic bus(input logic wr, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s);
    int n = 0;
    sram_req = 1'b1; sram_write = wr; sram_addr = a; sram_wdata = d; sram_wstrb = s;
    while (!sram_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!sram_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      sram_req = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      acc_cyc  = cyc;
      sram_req = 1'b0;
      if (wr) begin
        for (int b = 0; b < 4; b++)
          if (s[b]) ref_mem[a[18:2]][8*b +: 8] = d[8*b +: 8];
      end else begin
        exp_q.push_back(ref_mem[a[18:2]]);
      end
    end
  endtask

  task automatic settle();
    repeat (10) @(negedge clk);
  endtask

  task automatic clear_logs();
    plog.delete();
    busy_cnt = 0;
  endtask

  int n_we, n_oe, n_dqoe, n_ovl, n_hi_ok, a0, a1, rv0, n_rd, wait_n;
  logic [31:0] ra, rd;
  logic [3:0]  rs;
  logic        rw;

  task automatic count_log();
    n_we = 0; n_oe = 0; n_dqoe = 0; n_ovl = 0; n_hi_ok = 0;
    foreach (plog[i]) begin
      if (!plog[i].we) n_we++;
      if (!plog[i].oe) n_oe++;
      if (plog[i].dq_oe) n_dqoe++;
      if (!plog[i].we && !plog[i].oe) n_ovl++;
      if (plog[i].a == 18'h9 && plog[i].ub && !plog[i].lb) n_hi_ok++;
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << 18); i++) mem[i] = '0;
    for (int i = 0; i < (1 << 17); i++) ref_mem[i] = '0;

    // Reset state
    #12;
    check("rst_ready", 32'(sram_ready), 32'd1);
    check("rst_rvalid", 32'(sram_rvalid), 32'd0);
    check("rst_rdata", sram_rdata, 32'd0);
    check("rst_addr", 32'(ext_addr), 32'd0);
    check("rst_pins", {16'(ext_dq_out), 10'd0, ext_ce_n, ext_oe_n, ext_we_n, ext_ub_n,
                       ext_lb_n, ext_dq_oe}, 32'h0000_003E);
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);

    // 1: full write
    clear_logs();
    bus(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
    settle();
    count_log();
    check("t1_len", 32'(plog.size()), 32'd6);
    check("t1_lo", {plog[0].a, plog[0].d[13:0]}, {18'h8, 14'h3EEF});
    check("t1_lo_dq", 32'(plog[0].d), 32'hBEEF);
    check("t1_hi_a", 32'(plog[5].a), 32'h9);
    check("t1_hi_dq", 32'(plog[5].d), 32'hDEAD);
    check("t1_we_low", 32'(n_we), 32'd4);
    check("t1_busy", 32'(busy_cnt), 32'd6);
    check("t1_mem", {mem[9], mem[8]}, 32'hDEAD_BEEF);

    // 2: read-back
    clear_logs();
    rv0 = rv_cnt;
    bus(1'b0, 32'h10, 32'h0, 4'h0);
    a0 = acc_cyc;
    settle();
    count_log();
    check("t2_rv_cnt", 32'(rv_cnt - rv0), 32'd1);
    check("t2_latency", 32'(rv_cyc - a0), 32'd4);
    check("t2_oe_low", 32'(n_oe), 32'd4);
    check("t2_dq_oe", 32'(n_dqoe), 32'd0);
    check("t2_hold", sram_rdata, 32'hDEAD_BEEF);

    // 3: partial writes
    clear_logs();
    bus(1'b1, 32'h10, 32'h0055_0000, 4'h4);
    settle();
    count_log();
    check("t3_len", 32'(plog.size()), 32'd3);
    check("t3_hi_only", 32'(n_hi_ok), 32'd3);
    bus(1'b0, 32'h10, 32'h0, 4'h0);
    settle();
    check("t3_rb", sram_rdata, 32'hDE55_BEEF);
    clear_logs();
    bus(1'b1, 32'h10, 32'hFFFF_FFFF, 4'h0);
    settle();
    check("t3_nostrb_pins", 32'(plog.size()), 32'd0);
    check("t3_nostrb_busy", 32'(busy_cnt), 32'd1);

    // 4: back-to-back requests
    clear_logs();
    bus(1'b0, 32'h10, 32'h0, 4'h0);
    a0 = acc_cyc;
    bus(1'b1, 32'h20, 32'h1234_5678, 4'hF);
    a1 = acc_cyc;
    settle();
    count_log();
    check("t4_accept_gap", 32'(a1 - a0), 32'd6);
    check("t4_overlap", 32'(n_ovl), 32'd0);
    check("t4_len", 32'(plog.size()), 32'd10);
    bus(1'b0, 32'h20, 32'h0, 4'h0);
    settle();

    // 5: reset during the high read phase
    bus(1'b0, 32'h10, 32'h0, 4'h0);
    wait_n = 0;
    while (!(!ext_ce_n && ext_addr[0]) && wait_n < 20) begin
      @(negedge clk);
      wait_n++;
    end
    check("t5_reached_hi", 32'(ext_addr[0] & ~ext_ce_n), 32'd1);
    rv0 = rv_cnt;
    rst_b = 1'b0;
    #1;
    check("t5_pins", {26'd0, ext_ce_n, ext_oe_n, ext_we_n, ext_ub_n, ext_lb_n, ext_dq_oe},
          32'h0000_003E);
    check("t5_ready", 32'(sram_ready), 32'd1);
    void'(exp_q.pop_back());
    repeat (3) @(negedge clk);
    rst_b = 1'b1;
    settle();
    check("t5_no_rv", 32'(rv_cnt - rv0), 32'd0);
    bus(1'b0, 32'h10, 32'h0, 4'h0);
    settle();
    check("t5_rb", sram_rdata, 32'hDE55_BEEF);

    // 6: random traffic against the scoreboard
    rv0  = rv_cnt;
    n_rd = 0;
    for (int i = 0; i < 1000; i++) begin
      rw = 1'($urandom_range(0, 1));
      ra = ($urandom() & ~32'h0007_FFFC) | (32'($urandom_range(0, 15)) << 2);
      rd = $urandom();
      rs = 4'($urandom_range(0, 15));
      if (!rw) n_rd++;
      bus(rw, ra, rd, rs);
    end
    settle();
    check("t6_rv_count", 32'(rv_cnt - rv0), 32'(n_rd));
    check("t6_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
